// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Adds two 4*NIBBLES-bit operands through one shared 4-bit
//               ripple-carry slice, one nibble per clock, LS nibble first.
// Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_step;
    logic            w_last;

    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_done;

    logic [IDXW+1:0] w_sh;
    logic [3:0]      w_slice_a;
    logic [3:0]      w_slice_b;
    logic [3:0]      w_s;
    logic            w_co;
    logic [W-1:0]    w_acc_next;

    // Shared 4-bit slice, selected nibble addressed by r_idx
    assign w_sh      = {r_idx, 2'b00};
    assign w_slice_a = 4'(r_op_a >> w_sh);
    assign w_slice_b = 4'(r_op_b >> w_sh);
    assign {w_co, w_s} = 5'(w_slice_a) + 5'(w_slice_b) + 5'(r_carry);
    assign w_acc_next  = (r_acc & ~(W'(4'hF) << w_sh)) | (W'(w_s) << w_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_idx == c_last_idx) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_op_a  <= a;
                r_op_b  <= b;
                r_carry <= cin;
                r_idx   <= '0;
                r_acc   <= '0;
            end else if (w_step) begin
                r_acc   <= w_acc_next;
                r_carry <= w_co;
                r_idx   <= r_idx + 1'b1;
            end
            // Outputs only move on completion, never exposing partial sums
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_co;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Scoreboard bench: random and directed adds versus an
//               arithmetic reference, plus a NIBBLES=1 instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         s1_start = 1'b0;
    logic [3:0]   s1_a = '0;
    logic [3:0]   s1_b = '0;
    logic         s1_cin = 1'b0;
    logic         s1_busy, s1_done, s1_cout;
    logic [3:0]   s1_sum;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_done = 0;

    logic [W:0] exp_q[$];
    int         acc_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding add
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                int t;
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                chk("sum", 32'(sum), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
                chk("latency", 32'(cyc - t), 32'(N));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input bit expect_it);
        int guard;
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("issue_timeout", 32'd1, 32'd0);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        if (expect_it) begin
            exp_q.push_back({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
            acc_q.push_back(cyc);
        end
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int d0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);

        // Basic add with busy duration check
        issue(16'h1234, 16'h4321, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < N + 2; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(N));
        drain();

        issue(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        drain();

        // Start during RUN must be ignored
        d0 = n_done;
        issue(16'h0001, 16'h0002, 1'b0, 1'b1);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("ignored_start_done_count", 32'(n_done - d0), 32'd1);

        // Back-to-back: second issue lands in the done cycle
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drain();

        // Random traffic, frequently back-to-back
        for (int k = 0; k < 40; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // Async reset mid-cycle, two cycles into RUN, aborts the add
        issue(16'h8001, 16'h8001, 1'b1, 1'b0);
        @(posedge clk); #3;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_sum", 32'(sum), 32'd0);
        chk("async_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = n_done;
        repeat (N + 4) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);

        // Single-nibble instance: RUN lasts one cycle
        for (int k = 0; k < 6; k++) begin
            logic [3:0] ta, tb;
            logic       tc;
            logic [4:0] e;
            if (k == 0) begin ta = 4'hF; tb = 4'h1; tc = 1'b0; end
            else begin ta = 4'($urandom); tb = 4'($urandom); tc = 1'($urandom); end
            e = {1'b0, ta} + {1'b0, tb} + 5'(tc);
            @(negedge clk);
            s1_a = ta; s1_b = tb; s1_cin = tc; s1_start = 1'b1;
            @(posedge clk); #1;
            s1_start = 1'b0;
            chk("n1_busy", 32'(s1_busy), 32'd1);
            chk("n1_done_early", 32'(s1_done), 32'd0);
            @(posedge clk); #1;
            chk("n1_done", 32'(s1_done), 32'd1);
            chk("n1_busy_after", 32'(s1_busy), 32'd0);
            chk("n1_sum", 32'(s1_sum), 32'(e[3:0]));
            chk("n1_cout", 32'(s1_cout), 32'(e[4]));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
